// File: rtl/llki_pkg.sv
// Shared LLKI shim types and constants: key word width and the key-load FSM state encoding.
package llki_pkg;

    localparam int LLKI_SHIM_WORD_W = 64;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        WAIT_LOAD  = 3'd1,
        WAIT_NEXT  = 3'd2,
        WAIT_DONE  = 3'd3,
        CLEAR      = 3'd4,
        WAIT_CLEAR = 3'd5
    } LLKI_SHIM_STATE_TYPE;

endpackage

// File: rtl/llki_wait_counter.sv
// Loadable down-counter that saturates at zero; used for artificial wait states and the inter-word timeout.
module llki_wait_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         en,
    input  logic [W-1:0] load_value,
    output logic         is_zero
);

    logic [W-1:0] count_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_reg <= '0;
        end else if (load) begin
            count_reg <= load_value;
        end else if (en && !is_zero) begin
            count_reg <= count_reg - 1'b1;
        end
    end

    assign is_zero = (count_reg == '0);

endmodule

// File: rtl/llki_key_shim_fsm.sv
// LLKI TSS key-load FSM: assembles KEY_WORDS 64-bit words into a key register with wait states and zeroize.
// Optional inter-word timeout enabled by defining LLKI_SHIM_TIMEOUT_EN.
module llki_key_shim_fsm
    import llki_pkg::*;
#(
    parameter int KEY_WORDS      = 2,
    parameter int WAIT_CYCLES    = 3,
    parameter int LOAD_ORDER     = 0,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [LLKI_SHIM_WORD_W-1:0]       llkid_key_data,
    input  logic                              llkid_key_valid,
    output logic                              llkid_key_ready,
    output logic                              llkid_key_complete,
    input  logic                              llkid_clear_key,
    output logic                              llkid_clear_key_ack,
    output logic                              llkid_load_error,
    output logic                              llkid_busy,
    output logic [7:0]                        llkid_word_count,
    output logic [LLKI_SHIM_WORD_W*KEY_WORDS-1:0] llkid_key_register
);

    localparam logic [2:0] ST_IDLE       = IDLE;
    localparam logic [2:0] ST_WAIT_LOAD  = WAIT_LOAD;
    localparam logic [2:0] ST_WAIT_NEXT  = WAIT_NEXT;
    localparam logic [2:0] ST_WAIT_DONE  = WAIT_DONE;
    localparam logic [2:0] ST_CLEAR      = CLEAR;
    localparam logic [2:0] ST_WAIT_CLEAR = WAIT_CLEAR;

    localparam int KEY_W = LLKI_SHIM_WORD_W * KEY_WORDS;

    logic [2:0]       state_reg;
    logic             ready_reg;
    logic             complete_reg;
    logic             ack_reg;
    logic             error_reg;
    logic [7:0]       word_count_reg;
    logic [KEY_W-1:0] key_reg;

    logic             accept;
    logic             last_word;
    logic             wait_load;
    logic             wait_en;
    logic             wait_zero;
    logic             timeout_hit;
    logic             zeroize;
    logic             store_en;
    logic [7:0]       store_slot;
    logic [7:0]       slot_idx;
    logic [KEY_WORDS-1:0] slot_hit;

    assign accept    = llkid_key_valid && ready_reg;
    assign last_word = (word_count_reg == 8'(KEY_WORDS));

    always_comb begin
        wait_load = 1'b0;
        wait_en   = 1'b0;
        case (state_reg)
            ST_IDLE, ST_WAIT_NEXT: wait_load = accept && !llkid_clear_key;
            ST_WAIT_LOAD: begin
                wait_load = !llkid_clear_key && wait_zero && last_word;
                wait_en   = 1'b1;
            end
            ST_WAIT_DONE, ST_WAIT_CLEAR: wait_en = 1'b1;
            ST_CLEAR: wait_load = 1'b1;
            default: wait_load = 1'b0;
        endcase
    end

    llki_wait_counter #(.W(8)) u_wait_counter (
        .clk        (clk),
        .rst        (rst),
        .load       (wait_load),
        .en         (wait_en),
        .load_value (8'(WAIT_CYCLES)),
        .is_zero    (wait_zero)
    );

`ifdef LLKI_SHIM_TIMEOUT_EN
    // Held at reload outside WAIT_NEXT so each entry starts a fresh idle window.
    logic timeout_zero;

    llki_wait_counter #(.W(16)) u_timeout_counter (
        .clk        (clk),
        .rst        (rst),
        .load       (state_reg != ST_WAIT_NEXT),
        .en         (!llkid_key_valid),
        .load_value (16'(TIMEOUT_CYCLES - 1)),
        .is_zero    (timeout_zero)
    );

    assign timeout_hit = (state_reg == ST_WAIT_NEXT) && timeout_zero && !llkid_key_valid;
`else
    assign timeout_hit = 1'b0;
`endif

    // A new load always restarts at slot 0, even if word_count still shows the previous key.
    assign store_slot = (state_reg == ST_IDLE) ? 8'd0 : word_count_reg;
    assign slot_idx   = (LOAD_ORDER == 0) ? store_slot : (8'(KEY_WORDS - 1) - store_slot);
    assign store_en   = accept && !llkid_clear_key &&
                        ((state_reg == ST_IDLE) || (state_reg == ST_WAIT_NEXT));

    generate
        for (genvar gi = 0; gi < KEY_WORDS; gi++) begin : g_slot
            assign slot_hit[gi] = (slot_idx == 8'(gi));
        end
    endgenerate

    always_comb begin
        zeroize = 1'b0;
        case (state_reg)
            ST_IDLE, ST_WAIT_LOAD, ST_WAIT_DONE: zeroize = llkid_clear_key;
            ST_WAIT_NEXT:  zeroize = llkid_clear_key || timeout_hit;
            ST_CLEAR:      zeroize = 1'b1;
            ST_WAIT_CLEAR: zeroize = 1'b0;
            default:       zeroize = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            key_reg <= '0;
        end else if (zeroize) begin
            key_reg <= '0;
        end else if (store_en) begin
            for (int i = 0; i < KEY_WORDS; i++) begin
                if (slot_hit[i]) begin
                    key_reg[i*LLKI_SHIM_WORD_W +: LLKI_SHIM_WORD_W] <= llkid_key_data;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= ST_IDLE;
            ready_reg      <= 1'b1;
            complete_reg   <= 1'b0;
            ack_reg        <= 1'b0;
            error_reg      <= 1'b0;
            word_count_reg <= 8'd0;
        end else begin
            ack_reg   <= 1'b0;
            error_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    ready_reg <= 1'b1;
                    if (llkid_clear_key) begin
                        complete_reg   <= 1'b0;
                        word_count_reg <= 8'd0;
                        ack_reg        <= 1'b1;
                    end else if (accept) begin
                        complete_reg   <= 1'b0;
                        word_count_reg <= 8'd1;
                        ready_reg      <= 1'b0;
                        state_reg      <= ST_WAIT_LOAD;
                    end
                end
                ST_WAIT_LOAD: begin
                    if (llkid_clear_key) begin
                        word_count_reg <= 8'd0;
                        state_reg      <= ST_CLEAR;
                    end else if (wait_zero) begin
                        if (last_word) begin
                            state_reg <= ST_WAIT_DONE;
                        end else begin
                            ready_reg <= 1'b1;
                            state_reg <= ST_WAIT_NEXT;
                        end
                    end
                end
                ST_WAIT_NEXT: begin
                    if (llkid_clear_key || timeout_hit) begin
                        error_reg      <= !llkid_clear_key;
                        word_count_reg <= 8'd0;
                        ready_reg      <= 1'b0;
                        state_reg      <= ST_CLEAR;
                    end else if (accept) begin
                        word_count_reg <= word_count_reg + 8'd1;
                        ready_reg      <= 1'b0;
                        state_reg      <= ST_WAIT_LOAD;
                    end
                end
                ST_WAIT_DONE: begin
                    if (llkid_clear_key) begin
                        word_count_reg <= 8'd0;
                        state_reg      <= ST_CLEAR;
                    end else if (wait_zero) begin
                        complete_reg <= 1'b1;
                        ready_reg    <= 1'b1;
                        state_reg    <= ST_IDLE;
                    end
                end
                ST_CLEAR: begin
                    complete_reg   <= 1'b0;
                    word_count_reg <= 8'd0;
                    ready_reg      <= 1'b0;
                    state_reg      <= ST_WAIT_CLEAR;
                end
                ST_WAIT_CLEAR: begin
                    if (wait_zero) begin
                        ack_reg   <= 1'b1;
                        ready_reg <= 1'b1;
                        state_reg <= ST_IDLE;
                    end
                end
                default: begin
                    state_reg      <= ST_IDLE;
                    ready_reg      <= 1'b1;
                    complete_reg   <= 1'b0;
                    word_count_reg <= 8'd0;
                end
            endcase
        end
    end

    assign llkid_key_ready     = ready_reg;
    assign llkid_key_complete  = complete_reg;
    assign llkid_clear_key_ack = ack_reg;
    assign llkid_load_error    = error_reg;
    assign llkid_busy          = (state_reg != ST_IDLE);
    assign llkid_word_count    = word_count_reg;
    assign llkid_key_register  = key_reg;

endmodule

// File: tb/tb_llki_key_shim_fsm.sv
// Directed bench for llki_key_shim_fsm: two instances (ascending and descending load order) share stimulus.
module tb_llki_key_shim_fsm;

    logic         clk = 1'b0;
    logic         rst;
    logic [63:0]  data;
    logic         valid;
    logic         clear;

    logic         ready0, complete0, ack0, err0, busy0;
    logic [7:0]   wc0;
    logic [127:0] key0;
    logic         ready1, complete1, ack1, err1, busy1;
    logic [7:0]   wc1;
    logic [127:0] key1;

    int checks = 0;
    int errors = 0;

    localparam logic [63:0] WA = 64'hA0A1_A2A3_A4A5_A6A7;
    localparam logic [63:0] WB = 64'hB0B1_B2B3_B4B5_B6B7;
    localparam logic [63:0] WC = 64'hC0C1_C2C3_C4C5_C6C7;
    localparam logic [63:0] WD = 64'hD0D1_D2D3_D4D5_D6D7;

    always #5 clk = ~clk;

    llki_key_shim_fsm #(.KEY_WORDS(2), .WAIT_CYCLES(3), .LOAD_ORDER(0), .TIMEOUT_CYCLES(8)) dut0 (
        .clk(clk), .rst(rst), .llkid_key_data(data), .llkid_key_valid(valid),
        .llkid_key_ready(ready0), .llkid_key_complete(complete0), .llkid_clear_key(clear),
        .llkid_clear_key_ack(ack0), .llkid_load_error(err0), .llkid_busy(busy0),
        .llkid_word_count(wc0), .llkid_key_register(key0)
    );

    llki_key_shim_fsm #(.KEY_WORDS(2), .WAIT_CYCLES(3), .LOAD_ORDER(1), .TIMEOUT_CYCLES(8)) dut1 (
        .clk(clk), .rst(rst), .llkid_key_data(data), .llkid_key_valid(valid),
        .llkid_key_ready(ready1), .llkid_key_complete(complete1), .llkid_clear_key(clear),
        .llkid_clear_key_ack(ack1), .llkid_load_error(err1), .llkid_busy(busy1),
        .llkid_word_count(wc1), .llkid_key_register(key1)
    );

`define CHK(tag, obs, exp) begin checks++; assert ((obs) === (exp)) else begin errors++; $error("FAIL %s: observed %0h expected %0h", tag, (obs), (exp)); end end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Two-word load; word0 accepted at cycle 0, checks ready/complete timeline through cycle 14.
    task automatic run_load(input logic [63:0] a, input logic [63:0] b);
        valid = 1'b1;
        data  = a;
        tick();
        data  = b;
        `CHK("wc_first", wc0, 8'd1)
        for (int c = 1; c <= 13; c++) begin
            `CHK("ready_seq", ready0, (c == 5))
            `CHK("complete_low", complete0, 1'b0)
            if (c == 6) begin
                `CHK("wc_second", wc0, 8'd2)
                `CHK("wc_second_rev", wc1, 8'd2)
                valid = 1'b0;
            end
            tick();
        end
        `CHK("complete_c14", complete0, 1'b1)
        `CHK("complete_c14_rev", complete1, 1'b1)
        `CHK("ready_c14", ready0, 1'b1)
        `CHK("busy_c14", busy0, 1'b0)
        `CHK("key_asc", key0, {b, a})
        `CHK("key_desc", key1, {a, b})
        $display("load %h %h -> asc %h desc %h", a, b, key0, key1);
    endtask

    initial begin
        int ack_n, ack_first, err_n, err_first;
        rst   = 1'b1;
        valid = 1'b0;
        clear = 1'b0;
        data  = '0;
        tick();
        tick();
        `CHK("rst_ready", ready0, 1'b1)
        `CHK("rst_complete", complete0, 1'b0)
        `CHK("rst_ack", ack0, 1'b0)
        `CHK("rst_err", err0, 1'b0)
        `CHK("rst_busy", busy0, 1'b0)
        `CHK("rst_wc", wc0, 8'd0)
        `CHK("rst_key", key0, 128'd0)
        $display("reset released");
        rst = 1'b0;
        tick();

        // Tests 1 and 2
        run_load(WA, WB);

        // Test 4: clear in IDLE with a complete key
        clear = 1'b1;
        tick();
        clear = 1'b0;
        `CHK("idle_clr_key", key0, 128'd0)
        `CHK("idle_clr_complete", complete0, 1'b0)
        `CHK("idle_clr_ack", ack0, 1'b1)
        tick();
        `CHK("idle_clr_ack_drop", ack0, 1'b0)
        $display("idle clear done");

        clear = 1'b1;
        valid = 1'b1;
        data  = WC;
        tick();
        clear = 1'b0;
        valid = 1'b0;
        `CHK("clr_valid_key", key0, 128'd0)
        `CHK("clr_valid_busy", busy0, 1'b0)
        `CHK("clr_valid_ack", ack0, 1'b1)
        $display("clear with valid: word dropped");
        tick();

        // Test 3: clear in WAIT_NEXT after word A
        valid = 1'b1;
        data  = WA;
        tick();
        valid = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        `CHK("next_ready", ready0, 1'b1)
        `CHK("partial_asc", key0, {64'd0, WA})
        `CHK("partial_desc", key1, {WA, 64'd0})
        clear = 1'b1;
        tick();
        clear = 1'b0;
        `CHK("next_clr_key", key0, 128'd0)
        `CHK("next_clr_wc", wc0, 8'd0)
        `CHK("next_clr_ack0", ack0, 1'b0)
        ack_n = 0;
        ack_first = 0;
        for (int t = 2; t <= 9; t++) begin
            clear = (t == 4);
            tick();
            clear = 1'b0;
            if (ack0) begin
                ack_n++;
                if (ack_first == 0) ack_first = t;
            end
        end
        `CHK("next_clr_ack_count", ack_n, 1)
        `CHK("next_clr_ack_time", ack_first, 6)
        $display("wait-next clear: ack at %0d (count %0d)", ack_first, ack_n);

        // Test 5: word A then silence
        valid = 1'b1;
        data  = WA;
        tick();
        valid = 1'b0;
        ack_n = 0; ack_first = 0; err_n = 0; err_first = 0;
        for (int t = 2; t <= 40; t++) begin
            tick();
            if (err0) begin
                err_n++;
                if (err_first == 0) err_first = t;
            end
            if (ack0) begin
                ack_n++;
                if (ack_first == 0) ack_first = t;
            end
        end
`ifdef LLKI_SHIM_TIMEOUT_EN
        `CHK("to_err_count", err_n, 1)
        `CHK("to_err_time", err_first, 13)
        `CHK("to_ack_time", ack_first, 18)
        `CHK("to_key", key0, 128'd0)
        `CHK("to_busy", busy0, 1'b0)
        $display("timeout: error at %0d, ack at %0d", err_first, ack_first);
`else
        `CHK("noto_err_count", err_n, 0)
        `CHK("noto_ack_count", ack_n, 0)
        `CHK("noto_busy", busy0, 1'b1)
        `CHK("noto_ready", ready0, 1'b1)
        `CHK("noto_key", key0, {64'd0, WA})
        $display("no timeout: still waiting after 40 cycles");
        clear = 1'b1;
        tick();
        clear = 1'b0;
        ack_n = 0;
        for (int t = 2; t <= 9; t++) begin
            tick();
            if (ack0) ack_n++;
        end
        `CHK("noto_clear_ack", ack_n, 1)
`endif
        tick();

        // Test 6: async reset in WAIT_DONE
        valid = 1'b1;
        data  = WA;
        tick();
        data  = WB;
        for (int i = 0; i < 5; i++) tick();
        valid = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        `CHK("wd_busy", busy0, 1'b1)
        `CHK("wd_ready", ready0, 1'b0)
        #2;
        rst = 1'b1;
        #1;
        `CHK("arst_ready", ready0, 1'b1)
        `CHK("arst_busy", busy0, 1'b0)
        `CHK("arst_wc", wc0, 8'd0)
        `CHK("arst_key", key0, 128'd0)
        `CHK("arst_complete", complete0, 1'b0)
        tick();
        rst = 1'b0;
        `CHK("arst_ack", ack0, 1'b0)
        $display("async reset in wait-done applied");
        tick();
        run_load(WC, WD);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
